// File: rtl/hazard_scoreboard_if.sv
// Issue / ID-read / stall bundle between the pipeline control and hazard_scoreboard.
// The pipeline side uses the master modport; the scoreboard uses the slave modport.
interface hazard_scoreboard_if #(
    parameter int LAT_W = 2,
    parameter int CNT_W = 32
);
    logic             issue_valid_i;
    logic             issue_we_i;
    logic [4:0]       issue_rd_i;
    logic [LAT_W-1:0] issue_lat_i;
    logic             squash_i;
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_rt_used_i;
    logic             stall_o;
    logic [31:0]      busy_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output issue_valid_i, issue_we_i, issue_rd_i, issue_lat_i, squash_i,
        output id_rs_i, id_rt_i, id_rt_used_i,
        input  stall_o, busy_o, stall_cnt_o
    );

    modport slave (
        input  issue_valid_i, issue_we_i, issue_rd_i, issue_lat_i, squash_i,
        input  id_rs_i, id_rt_i, id_rt_used_i,
        output stall_o, busy_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register latency countdown scoreboard that holds ID until a producer's result is forwardable.
// Optional stall performance counter: define HAZARD_SB_STALL_CNT_EN to build it.
module hazard_scoreboard #(
    parameter int LAT_W = 2,
    parameter int CNT_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hazard_scoreboard_if.slave   sb
);

    logic [LAT_W-1:0] cnt_q [32];
    logic [LAT_W-1:0] cnt_d [32];
    logic [4:0]       last_rd_q;
    logic             last_vld_q;
    logic             acc;
    logic             rs_hit;
    logic             rt_hit;

    // NOTE: combinational signals get a default at the top of the block so no path infers a latch.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        if (sb.id_rs_i != 5'd0 && cnt_q[sb.id_rs_i] != '0) rs_hit = 1'b1;
        if (sb.id_rt_used_i && sb.id_rt_i != 5'd0 && cnt_q[sb.id_rt_i] != '0) rt_hit = 1'b1;
    end

    assign sb.stall_o = rs_hit | rt_hit;
    assign acc = sb.issue_valid_i & sb.issue_we_i & (sb.issue_rd_i != 5'd0) & ~sb.stall_o;

    // A fresh issue outranks a squash of the previous issue, which outranks the countdown.
    always_comb begin
        cnt_d    = cnt_q;
        cnt_d[0] = '0;
        for (int r = 1; r < 32; r++) begin
            if (acc && sb.issue_rd_i == 5'(r)) begin
                cnt_d[r] = sb.issue_lat_i;
            end else if (sb.squash_i && last_vld_q && last_rd_q == 5'(r)) begin
                cnt_d[r] = '0;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the counter array is reset because stall_o must read as 0 the instant reset asserts.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
            last_rd_q  <= 5'd0;
            last_vld_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            last_rd_q  <= sb.issue_rd_i;
            last_vld_q <= acc;
        end
    end

    always_comb begin
        sb.busy_o = '0;
        for (int r = 1; r < 32; r++) sb.busy_o[r] = (cnt_q[r] != '0);
    end

`ifdef HAZARD_SB_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturates rather than wraps so a long run never reports a small count.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (sb.stall_o && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign sb.stall_cnt_o = stall_cnt_q;
`else
    assign sb.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; one task per scenario.
// Stall-counter expectations follow HAZARD_SB_STALL_CNT_EN as defined for the build.
module tb_hazard_scoreboard;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_sc = 0;

    hazard_scoreboard_if #(.LAT_W(2), .CNT_W(32)) sb ();

    hazard_scoreboard #(.LAT_W(2), .CNT_W(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sb    (sb.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive_idle();
        sb.issue_valid_i = 1'b0;
        sb.issue_we_i    = 1'b0;
        sb.issue_rd_i    = 5'd0;
        sb.issue_lat_i   = 2'd0;
        sb.squash_i      = 1'b0;
        sb.id_rs_i       = 5'd0;
        sb.id_rt_i       = 5'd0;
        sb.id_rt_used_i  = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [1:0] lat);
        sb.issue_valid_i = 1'b1;
        sb.issue_we_i    = 1'b1;
        sb.issue_rd_i    = rd;
        sb.issue_lat_i   = lat;
    endtask

    task automatic no_issue();
        sb.issue_valid_i = 1'b0;
        sb.issue_we_i    = 1'b0;
    endtask

    // exp_st is the hand-computed stall level at the coming edge, used for the counter model.
    task automatic tick(input bit exp_st);
        if (exp_st) exp_sc++;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] sc_expect();
`ifdef HAZARD_SB_STALL_CNT_EN
        return 32'(exp_sc);
`else
        return 32'd0;
`endif
    endfunction

    task automatic test_reset();
        drive_idle();
        #1;
        n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0b want 0", sb.stall_o); end
        n_cmp++; if (sb.busy_o !== 32'h0) begin n_bad++; $display("FAIL reset_busy: got %08h want 00000000", sb.busy_o); end
        n_cmp++; if (sb.stall_cnt_o !== 32'h0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", sb.stall_cnt_o); end
        #11 rst_i = 1'b1;
        tick(1'b0);
    endtask

    task automatic test_load_use();
        issue(5'd8, 2'd1);
        #1;
        n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL load_issue_stall: got %0b want 0", sb.stall_o); end
        tick(1'b0);
        no_issue();
        sb.id_rs_i = 5'd8;
        #1;
        n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL load_use_stall: got %0b want 1", sb.stall_o); end
        n_cmp++; if (sb.busy_o !== 32'h0000_0100) begin n_bad++; $display("FAIL load_use_busy: got %08h want 00000100", sb.busy_o); end
        tick(1'b1);
        n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL load_use_release: got %0b want 0", sb.stall_o); end
        n_cmp++; if (sb.busy_o !== 32'h0) begin n_bad++; $display("FAIL load_use_busy_clr: got %08h want 00000000", sb.busy_o); end
        n_cmp++; if (sb.stall_cnt_o !== sc_expect()) begin n_bad++; $display("FAIL load_use_stall_cnt: got %0d want %0d", sb.stall_cnt_o, sc_expect()); end
        drive_idle();
    endtask

    task automatic test_alu_use();
        issue(5'd9, 2'd0);
        #1;
        tick(1'b0);
        no_issue();
        sb.id_rt_i      = 5'd9;
        sb.id_rt_used_i = 1'b1;
        #1;
        n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL alu_use_stall: got %0b want 0", sb.stall_o); end
        n_cmp++; if (sb.busy_o !== 32'h0) begin n_bad++; $display("FAIL alu_use_busy: got %08h want 00000000", sb.busy_o); end
        tick(1'b0);
        n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL alu_use_stall2: got %0b want 0", sb.stall_o); end
        drive_idle();
    endtask

    task automatic test_zero_reg_unused_rt();
        issue(5'd0, 2'd3);
        #1;
        tick(1'b0);
        n_cmp++; if (sb.busy_o !== 32'h0) begin n_bad++; $display("FAIL zero_reg_busy: got %08h want 00000000", sb.busy_o); end
        issue(5'd5, 2'd2);
        #1;
        tick(1'b0);
        no_issue();
        sb.id_rt_i      = 5'd5;
        sb.id_rt_used_i = 1'b0;
        #1;
        n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL unused_rt_stall: got %0b want 0", sb.stall_o); end
        n_cmp++; if (sb.busy_o !== 32'h0000_0020) begin n_bad++; $display("FAIL unused_rt_busy: got %08h want 00000020", sb.busy_o); end
        tick(1'b0);
        n_cmp++; if (sb.busy_o !== 32'h0000_0020) begin n_bad++; $display("FAIL unused_rt_busy2: got %08h want 00000020", sb.busy_o); end
        tick(1'b0);
        n_cmp++; if (sb.busy_o !== 32'h0) begin n_bad++; $display("FAIL unused_rt_busy_clr: got %08h want 00000000", sb.busy_o); end
        drive_idle();
    endtask

    task automatic test_squash();
        issue(5'd12, 2'd3);
        #1;
        tick(1'b0);
        no_issue();
        sb.squash_i = 1'b1;
        #1;
        n_cmp++; if (sb.busy_o !== 32'h0000_1000) begin n_bad++; $display("FAIL squash_busy_before: got %08h want 00001000", sb.busy_o); end
        tick(1'b0);
        sb.squash_i = 1'b0;
        sb.id_rs_i  = 5'd12;
        #1;
        n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL squash_stall: got %0b want 0", sb.stall_o); end
        n_cmp++; if (sb.busy_o !== 32'h0) begin n_bad++; $display("FAIL squash_busy_after: got %08h want 00000000", sb.busy_o); end

        sb.id_rs_i = 5'd0;
        issue(5'd12, 2'd3);
        #1;
        tick(1'b0);
        no_issue();
        sb.id_rs_i = 5'd12;
        #1;
        n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL multi_stall_c1: got %0b want 1", sb.stall_o); end
        tick(1'b1);
        n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL multi_stall_c2: got %0b want 1", sb.stall_o); end
        tick(1'b1);
        n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL multi_stall_c3: got %0b want 1", sb.stall_o); end
        tick(1'b1);
        n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL multi_stall_release: got %0b want 0", sb.stall_o); end
        n_cmp++; if (sb.stall_cnt_o !== sc_expect()) begin n_bad++; $display("FAIL multi_stall_cnt: got %0d want %0d", sb.stall_cnt_o, sc_expect()); end
        drive_idle();
    endtask

    task automatic test_overwrite();
        issue(5'd4, 2'd3);
        #1;
        tick(1'b0);
        issue(5'd4, 2'd1);
        sb.id_rs_i = 5'd4;
        #1;
        n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL ovw_stall_c1: got %0b want 1", sb.stall_o); end
        tick(1'b1);
        n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL ovw_ignored_c2: got %0b want 1", sb.stall_o); end
        tick(1'b1);
        n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL ovw_ignored_c3: got %0b want 1", sb.stall_o); end
        tick(1'b1);
        n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL ovw_drained: got %0b want 0", sb.stall_o); end
        tick(1'b0);
        no_issue();
        #1;
        n_cmp++; if (sb.busy_o !== 32'h0000_0010) begin n_bad++; $display("FAIL ovw_accept_busy: got %08h want 00000010", sb.busy_o); end
        n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL ovw_accept_stall: got %0b want 1", sb.stall_o); end
        tick(1'b1);
        n_cmp++; if (sb.busy_o !== 32'h0) begin n_bad++; $display("FAIL ovw_accept_clr: got %08h want 00000000", sb.busy_o); end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        issue(5'd7, 2'd2);
        #1;
        tick(1'b0);
        no_issue();
        sb.id_rs_i = 5'd7;
        #1;
        n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre_stall: got %0b want 1", sb.stall_o); end
        #1 rst_i = 1'b0;
        exp_sc = 0;
        #1;
        n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall: got %0b want 0", sb.stall_o); end
        n_cmp++; if (sb.busy_o !== 32'h0) begin n_bad++; $display("FAIL rst_mid_busy: got %08h want 00000000", sb.busy_o); end
        n_cmp++; if (sb.stall_cnt_o !== 32'h0) begin n_bad++; $display("FAIL rst_mid_stall_cnt: got %0d want 0", sb.stall_cnt_o); end
        #3 rst_i = 1'b1;
        tick(1'b0);
        issue(5'd7, 2'd1);
        #1;
        n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL rst_resume_stall: got %0b want 0", sb.stall_o); end
        tick(1'b0);
        no_issue();
        #1;
        n_cmp++; if (sb.busy_o !== 32'h0000_0080) begin n_bad++; $display("FAIL rst_resume_busy: got %08h want 00000080", sb.busy_o); end
        n_cmp++; if (sb.stall_o !== 1'b1) begin n_bad++; $display("FAIL rst_resume_dep: got %0b want 1", sb.stall_o); end
        tick(1'b1);
        n_cmp++; if (sb.stall_o !== 1'b0) begin n_bad++; $display("FAIL rst_resume_release: got %0b want 0", sb.stall_o); end
        n_cmp++; if (sb.stall_cnt_o !== sc_expect()) begin n_bad++; $display("FAIL rst_resume_stall_cnt: got %0d want %0d", sb.stall_cnt_o, sc_expect()); end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_use();
        test_zero_reg_unused_rt();
        test_squash();
        test_overwrite();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
